// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports, one debug port, one write port.
// Compile with REGFILE_BYPASS_EN defined to forward same-cycle write data onto read ports A and B.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_ok;
    logic              w_byp_rs;
    logic              w_byp_rt;

    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
        return (addr == {ADDR_W{1'b0}});
    endfunction

    // A write is real only when enabled, outside reset and not aimed at r0.
    assign w_wr_ok  = we && !rst && !is_zero_addr(wr_addr);
    assign w_byp_rs = w_wr_ok && (rs_addr == wr_addr);
    assign w_byp_rt = w_wr_ok && (rt_addr == wr_addr);

    // Array update: reset wins over any write presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end else begin
            r_mem[wr_addr] <= r_mem[wr_addr];
        end
    end

    // Read port A.
    always_comb begin
        rs_data = {DATA_W{1'b0}};
        if (is_zero_addr(rs_addr)) begin
            rs_data = {DATA_W{1'b0}};
        end
`ifdef REGFILE_BYPASS_EN
        else if (w_byp_rs) begin
            rs_data = wr_data;
        end
`endif
        else begin
            rs_data = r_mem[rs_addr];
        end
    end

    // Read port B.
    always_comb begin
        rt_data = {DATA_W{1'b0}};
        if (is_zero_addr(rt_addr)) begin
            rt_data = {DATA_W{1'b0}};
        end
`ifdef REGFILE_BYPASS_EN
        else if (w_byp_rt) begin
            rt_data = wr_data;
        end
`endif
        else begin
            rt_data = r_mem[rt_addr];
        end
    end

    // Debug port always shows raw array contents, never the in-flight write.
    always_comb begin
        dbg_data = {DATA_W{1'b0}};
        if (is_zero_addr(dbg_addr)) begin
            dbg_data = {DATA_W{1'b0}};
        end else begin
            dbg_data = r_mem[dbg_addr];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic vs. an array model.
// Expected read values honour REGFILE_BYPASS_EN so the bench works for either build.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    logic [31:0] model [32];
    bit          model_valid;
    int          n_checks;
    int          n_fail;
    bit          bypass_on;

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Value a read port should show this cycle, given the current inputs.
    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (bypass_on && we && !rst && wr_addr == addr) return wr_data;
        return model[addr];
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        return model[addr];
    endfunction

    // Check the current combinational reads, then clock one edge and update the model.
    task automatic step();
        #1;
        if (model_valid) begin
            check_eq("rs", rs_data, exp_read(rs_addr));
            check_eq("rt", rt_data, exp_read(rt_addr));
            check_eq("dbg", dbg_data, exp_dbg(dbg_addr));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            model_valid = 1'b1;
        end else if (we && wr_addr != 5'd0) begin
            model[wr_addr] = wr_data;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
        rst = r; we = w; wr_addr = wa; wr_data = wd;
        rs_addr = ra; rt_addr = rb; dbg_addr = da;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        model_valid = 1'b0;
`ifdef REGFILE_BYPASS_EN
        bypass_on = 1'b1;
`else
        bypass_on = 1'b0;
`endif
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        step();

        // All registers read zero after reset on every port.
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 5'(a));
            #1;
            check_eq("rst_rs", rs_data, 32'd0);
            check_eq("rst_rt", rt_data, 32'd0);
            check_eq("rst_dbg", dbg_data, 32'd0);
            step();
        end

        // r8 write then dual-port read.
        drive(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2, 5'd3);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 5'd8);
        #1;
        check_eq("r8_rs", rs_data, 32'hDEADBEEF);
        check_eq("r8_rt", rt_data, 32'hDEADBEEF);
        step();

        // Write to r0 is discarded, including during the write cycle itself.
        drive(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0);
        #1;
        check_eq("r0_wr_rs", rs_data, 32'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check_eq("r0_rs", rs_data, 32'd0);
        check_eq("r0_rt", rt_data, 32'd0);
        check_eq("r0_dbg", dbg_data, 32'd0);
        step();

        // Same-cycle write/read of r9.
        drive(1'b0, 1'b1, 5'd9, 32'h1, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 5'd9);
        #1;
        check_eq("byp_rs", rs_data, bypass_on ? 32'hA5A5A5A5 : 32'h1);
        check_eq("byp_rt", rt_data, bypass_on ? 32'hA5A5A5A5 : 32'h1);
        check_eq("byp_dbg", dbg_data, 32'h1);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 5'd9);
        #1;
        check_eq("post_byp_rs", rs_data, 32'hA5A5A5A5);
        step();

        // Reset beats a simultaneous write; bypass suppressed during reset.
        drive(1'b0, 1'b1, 5'd3, 32'h55, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b1, 1'b1, 5'd4, 32'h77, 5'd4, 5'd3, 5'd3);
        #1;
        check_eq("rstwr_rs", rs_data, 32'd0);
        check_eq("rstwr_rt", rt_data, 32'h55);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 5'd3);
        #1;
        check_eq("rst_r3", dbg_data, 32'd0);
        check_eq("rst_r4", rt_data, 32'd0);
        check_eq("rst_r8", model[8], 32'd0);
        step();

        // Extreme registers in consecutive cycles, then sweep the debug port.
        drive(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b1, 5'd1, 32'h1, 5'd0, 5'd0, 5'd0);
        step();
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'(a));
            #1;
            check_eq("sweep_dbg", dbg_data, (a == 31) ? 32'hFFFFFFFF : ((a == 1) ? 32'h1 : 32'd0));
            step();
        end

        // Randomized traffic with frequent read/write address collisions.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                  wa, $urandom(),
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
